// File: rtl/register_unloader_if.sv
// Handshake bundle for the register unloader: a wide word enters on the
// In/InValid/InReady channel and leaves as narrow chunks on the
// Out/OutValid/OutReady channel.
// The slave modport is the unloader's view. The master modport is the
// view of the environment that feeds the word and sinks the chunks.
// Optional macro REGISTER_UNLOADER_PARITY_EN adds the OutParity signal.
interface register_unloader_if #(
    parameter int width = 32,
    parameter int chunk = 8
);

    logic [width-1:0] In;
    logic             InValid;
    logic             InReady;
    logic [chunk-1:0] Out;
    logic             OutValid;
    logic             OutReady;
    logic             OutLast;
    logic             Busy;
`ifdef REGISTER_UNLOADER_PARITY_EN
    logic             OutParity;
`endif

`ifdef REGISTER_UNLOADER_PARITY_EN
    modport slave (
        input  In, InValid, OutReady,
        output InReady, Out, OutValid, OutLast, Busy, OutParity
    );

    modport master (
        output In, InValid, OutReady,
        input  InReady, Out, OutValid, OutLast, Busy, OutParity
    );
`else
    modport slave (
        input  In, InValid, OutReady,
        output InReady, Out, OutValid, OutLast, Busy
    );

    modport master (
        output In, InValid, OutReady,
        input  InReady, Out, OutValid, OutLast, Busy
    );
`endif

endinterface

// File: rtl/register_unloader.sv
// Register unloader: accepts one width-bit word and emits it as
// width/chunk chunks, most significant chunk first. The next word can be
// accepted on the same cycle as the last chunk of the current word, so a
// continuous stream of words drains without idle cycles.
// Optional macro REGISTER_UNLOADER_PARITY_EN adds an even-parity bit
// (OutParity) for the chunk currently on Out.
module register_unloader #(
    parameter int width = 32,
    parameter int chunk = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    register_unloader_if.slave  bus
);

    localparam int chunks = width / chunk;
    localparam int cwidth = (chunks > 1) ? $clog2(chunks) : 1;
    localparam logic [cwidth-1:0] lastCount = cwidth'(chunks - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [width-1:0]  sr;
    logic [width-1:0]  srNext;
    logic [cwidth-1:0] cnt;
    logic [cwidth-1:0] cntNext;

    logic              busy;
    logic              outLast;
    logic              chunkTaken;
    logic              inReady;
    logic              loadEvent;

    // Output decode. Outputs come straight from state, sr and cnt, so reset
    // clears them as soon as Reset rises. InReady also passes the
    // "last chunk taken" path, which allows back-to-back words.
    always_comb begin
        busy       = (state == SHIFT);
        outLast    = busy && (cnt == lastCount);
        chunkTaken = busy && bus.OutReady;
        inReady    = !Reset && (!busy || (chunkTaken && outLast));
        loadEvent  = bus.InValid && inReady;
    end

    // Next-state logic. A load takes priority because it covers both a
    // fresh word from IDLE and the no-bubble reload on the last chunk.
    // Draining to IDLE clears sr, so Out rests at zero between words.
    always_comb begin
        stateNext = state;
        srNext    = sr;
        cntNext   = cnt;
        if (loadEvent) begin
            stateNext = SHIFT;
            srNext    = bus.In;
            cntNext   = '0;
        end else if (chunkTaken) begin
            if (outLast) begin
                stateNext = IDLE;
                srNext    = '0;
                cntNext   = '0;
            end else begin
                srNext  = sr << chunk;
                cntNext = cnt + cwidth'(1);
            end
        end
    end

    // State register. An asynchronous reset discards any partly drained word.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            sr    <= srNext;
            cnt   <= cntNext;
        end
    end

    assign bus.Out      = sr[width-1 -: chunk];
    assign bus.OutValid = busy;
    assign bus.Busy     = busy;
    assign bus.OutLast  = outLast;
    assign bus.InReady  = inReady;

`ifdef REGISTER_UNLOADER_PARITY_EN
    // The parity bit is gated by busy, so it is zero in IDLE and in reset.
    // It follows Out, so it stays stable while the sink stalls.
    always_comb begin
        bus.OutParity = busy && (^sr[width-1 -: chunk]);
    end
`endif

endmodule

// File: tb/tb_register_unloader.sv
// Directed testbench for register_unloader. It uses one 32/8 instance for
// the main vector table and the reset sequence, and one 16/16 instance for
// the single-chunk (register slice) case.
// When REGISTER_UNLOADER_PARITY_EN is defined, the bench also checks OutParity.
module tb_register_unloader;

    logic Clock;
    logic Reset;

    int total;
    int bad;

    register_unloader_if #(.width(32), .chunk(8))  bus8 ();
    register_unloader_if #(.width(16), .chunk(16)) bus16 ();

    register_unloader #(.width(32), .chunk(8)) dut8 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus8.slave)
    );

    register_unloader #(.width(16), .chunk(16)) dut16 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus16.slave)
    );

    // Free-running clock. Rising edges occur at 5, 15, 25, ...
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic        inValid;
        logic [31:0] inWord;
        logic        outReady;
        logic        expValid;
        logic [7:0]  expOut;
        logic        expLast;
        logic        expInReady;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(logic iv, logic [31:0] iw, logic ordy,
                                   logic ev, logic [7:0] eo, logic el, logic eir);
        vec_t v;
        v.inValid    = iv;
        v.inWord     = iw;
        v.outReady   = ordy;
        v.expValid   = ev;
        v.expOut     = eo;
        v.expLast    = el;
        v.expInReady = eir;
        vecs.push_back(v);
    endfunction

    task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output of the 32/8 instance with the expected values.
    task automatic checkOutput(string tag, logic ev, logic [7:0] eo, logic el, logic eir);
        compare({tag, " OutValid"}, 32'(bus8.OutValid), 32'(ev));
        compare({tag, " Busy"},     32'(bus8.Busy),     32'(ev));
        compare({tag, " Out"},      32'(bus8.Out),      32'(eo));
        compare({tag, " OutLast"},  32'(bus8.OutLast),  32'(el));
        compare({tag, " InReady"},  32'(bus8.InReady),  32'(eir));
`ifdef REGISTER_UNLOADER_PARITY_EN
        compare({tag, " OutParity"}, 32'(bus8.OutParity), 32'(ev && (^eo)));
`endif
    endtask

    // Drive the inputs just after the falling edge, then sample the outputs
    // 1 ns later, well away from the next rising edge.
    task automatic applyStimulus(string tag, vec_t v);
        @(negedge Clock);
        bus8.InValid  = v.inValid;
        bus8.In       = v.inWord;
        bus8.OutReady = v.outReady;
        #1;
        checkOutput(tag, v.expValid, v.expOut, v.expLast, v.expInReady);
    endtask

    task automatic check16(string tag, logic ev, logic [15:0] eo, logic el, logic eir);
        compare({tag, " OutValid"}, 32'(bus16.OutValid), 32'(ev));
        compare({tag, " Out"},      32'(bus16.Out),      32'(eo));
        compare({tag, " OutLast"},  32'(bus16.OutLast),  32'(el));
        compare({tag, " InReady"},  32'(bus16.InReady),  32'(eir));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        bus8.InValid   = 1'b0;
        bus8.In        = '0;
        bus8.OutReady  = 1'b1;
        bus16.InValid  = 1'b0;
        bus16.In       = '0;
        bus16.OutReady = 1'b1;

        // While reset is held, the unloader is idle and refuses input.
        #2;
        checkOutput("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        check16("reset16", 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkOutput("post-reset", 1'b0, 8'h00, 1'b0, 1'b1);

        // Plain drain. The change to In while idle must be ignored.
        addVec(1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 1);
        addVec(0, 32'h00000000, 1, 1, 8'hA1, 0, 0);
        addVec(0, 32'h00000000, 1, 1, 8'hB2, 0, 0);
        addVec(0, 32'h00000000, 1, 1, 8'hC3, 0, 0);
        addVec(0, 32'hFFFFFFFF, 1, 1, 8'hD4, 1, 1);
        addVec(0, 32'h00000000, 1, 0, 8'h00, 0, 1);
        // Stall on the second chunk. A request during the stall is refused.
        addVec(1, 32'hA1B2C3D4, 0, 0, 8'h00, 0, 1);
        addVec(0, 32'h00000000, 1, 1, 8'hA1, 0, 0);
        addVec(0, 32'h00000000, 0, 1, 8'hB2, 0, 0);
        addVec(1, 32'h12345678, 0, 1, 8'hB2, 0, 0);
        addVec(0, 32'h00000000, 1, 1, 8'hB2, 0, 0);
        addVec(0, 32'h00000000, 1, 1, 8'hC3, 0, 0);
        addVec(0, 32'h00000000, 1, 1, 8'hD4, 1, 1);
        addVec(0, 32'h00000000, 1, 0, 8'h00, 0, 1);
        // Back-to-back words with InValid held high. Junk on In mid-word.
        addVec(1, 32'h11223344, 1, 0, 8'h00, 0, 1);
        addVec(1, 32'hDEADBEEF, 1, 1, 8'h11, 0, 0);
        addVec(1, 32'hDEADBEEF, 1, 1, 8'h22, 0, 0);
        addVec(1, 32'hDEADBEEF, 1, 1, 8'h33, 0, 0);
        addVec(1, 32'h55667788, 1, 1, 8'h44, 1, 1);
        addVec(1, 32'hCAFEF00D, 1, 1, 8'h55, 0, 0);
        addVec(1, 32'hCAFEF00D, 1, 1, 8'h66, 0, 0);
        addVec(1, 32'hCAFEF00D, 1, 1, 8'h77, 0, 0);
        addVec(0, 32'h00000000, 1, 1, 8'h88, 1, 1);
        addVec(0, 32'h00000000, 1, 0, 8'h00, 0, 1);
        // Stall on the last chunk. No reload until that chunk is taken.
        addVec(1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 1);
        addVec(0, 32'h00000000, 1, 1, 8'hA1, 0, 0);
        addVec(0, 32'h00000000, 1, 1, 8'hB2, 0, 0);
        addVec(0, 32'h00000000, 1, 1, 8'hC3, 0, 0);
        addVec(1, 32'h11223344, 0, 1, 8'hD4, 1, 0);
        addVec(0, 32'h00000000, 1, 1, 8'hD4, 1, 1);
        addVec(0, 32'h00000000, 1, 0, 8'h00, 0, 1);

        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset midway through a word, while B2 is on Out.
        applyStimulus("rst load", '{1'b1, 32'hA1B2C3D4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
        applyStimulus("rst A1",   '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0});
        applyStimulus("rst B2",   '{1'b0, 32'h00000000, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0});
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async rst", 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge Clock);
        #1;
        checkOutput("rst held", 1'b0, 8'h00, 1'b0, 1'b0);
        Reset = 1'b0;
        bus8.OutReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus($sformatf("after rst%0d", k),
                          '{1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
        end
        applyStimulus("0F load", '{1'b1, 32'h0F0F0F0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
        for (int k = 0; k < 4; k++) begin
            applyStimulus($sformatf("0F chunk%0d", k),
                          '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h0F, (k == 3), (k == 3)});
        end
        applyStimulus("0F idle", '{1'b0, 32'h00000000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});

`ifdef REGISTER_UNLOADER_PARITY_EN
        // Parity of chunks 01, 03, 07, 00 is 1, 0, 1, 0. The expected value is
        // computed in checkOutput. These lines also pin the literal bits.
        applyStimulus("par load", '{1'b1, 32'h01030700, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
        compare("par idle", 32'(bus8.OutParity), 32'd0);
        applyStimulus("par 01", '{1'b0, 32'h0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0});
        compare("par bit 01", 32'(bus8.OutParity), 32'd1);
        applyStimulus("par 03", '{1'b0, 32'h0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0});
        compare("par bit 03", 32'(bus8.OutParity), 32'd0);
        applyStimulus("par 03h", '{1'b0, 32'h0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0});
        applyStimulus("par 07", '{1'b0, 32'h0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0});
        compare("par bit 07", 32'(bus8.OutParity), 32'd1);
        applyStimulus("par 00", '{1'b0, 32'h0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1});
        compare("par bit 00", 32'(bus8.OutParity), 32'd0);
        applyStimulus("par end", '{1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
`endif

        // Single-chunk instance: it behaves as a one-deep register slice
        // that streams two words back to back.
        @(negedge Clock);
        bus16.InValid = 1'b1;
        bus16.In      = 16'hBEEF;
        #1;
        check16("w16 load", 1'b0, 16'h0000, 1'b0, 1'b1);
        @(negedge Clock);
        bus16.In = 16'h1234;
        #1;
        check16("w16 BEEF", 1'b1, 16'hBEEF, 1'b1, 1'b1);
        @(negedge Clock);
        bus16.InValid = 1'b0;
        bus16.In      = 16'h0000;
        #1;
        check16("w16 1234", 1'b1, 16'h1234, 1'b1, 1'b1);
        @(negedge Clock);
        #1;
        check16("w16 idle", 1'b0, 16'h0000, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
